// File: rtl/gene_sweep_pkg.sv
// Shared types and defaults for the gene network initial-state sweep.
package gene_sweep_pkg;

    localparam int unsigned GENE_W_DEF    = 8;
    localparam int unsigned MAX_STEPS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        REPORT,
        DONE
    } sweep_state_t;

    localparam logic [1:0] KIND_FIXED   = 2'b00;
    localparam logic [1:0] KIND_CYCLE2  = 2'b01;
    localparam logic [1:0] KIND_TIMEOUT = 2'b10;

endpackage

// File: rtl/gene_orbit_monitor.sv
// Tracks recent network samples and the step count, and flags orbit termination.
// GENE_SWEEP_CYCLE2_DETECT_EN adds period-2 orbit detection.
module gene_orbit_monitor
    import gene_sweep_pkg::*;
#(
    parameter int unsigned W         = GENE_W_DEF,
    parameter int unsigned MAX_STEPS = MAX_STEPS_DEF,
    parameter int unsigned SW        = $clog2(MAX_STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic [W-1:0]  net_state,
    output logic [SW-1:0] step_cnt,
    output logic          term_c,
    output logic [1:0]    kind_c
);

    logic [W-1:0] prev;
    logic         prev_valid;
    logic         fixed_c;
    logic         cycle2_c;
    logic         limit_c;

    assign fixed_c = prev_valid && (net_state == prev);
    assign limit_c = (step_cnt == SW'(MAX_STEPS - 1));

`ifdef GENE_SWEEP_CYCLE2_DETECT_EN
    logic [W-1:0] prev2;
    logic         prev2_valid;

    assign cycle2_c = prev2_valid && (net_state == prev2) && (net_state != prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev2       <= '0;
            prev2_valid <= 1'b0;
        end else if (clear) begin
            prev2_valid <= 1'b0;
        end else if (advance && !term_c) begin
            prev2       <= prev;
            prev2_valid <= prev_valid;
        end
    end
`else
    assign cycle2_c = 1'b0;
`endif

    // FIXED outranks CYCLE2, which outranks TIMEOUT
    always_comb begin
        kind_c = KIND_TIMEOUT;
        if (fixed_c) begin
            kind_c = KIND_FIXED;
        end else if (cycle2_c) begin
            kind_c = KIND_CYCLE2;
        end
        term_c = fixed_c || cycle2_c || limit_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            step_cnt   <= '0;
        end else if (clear) begin
            prev_valid <= 1'b0;
            step_cnt   <= '0;
        end else if (advance && !term_c) begin
            prev       <= net_state;
            prev_valid <= 1'b1;
            step_cnt   <= step_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/gene_sweep_controller.sv
// Sweeps the gene network over every initial state and reports how each orbit ends.
// GENE_SWEEP_CYCLE2_DETECT_EN enables CYCLE2 records (see gene_orbit_monitor).
module gene_sweep_controller
    import gene_sweep_pkg::*;
#(
    parameter  int unsigned W         = GENE_W_DEF,
    parameter  int unsigned MAX_STEPS = MAX_STEPS_DEF,
    localparam int unsigned SW        = $clog2(MAX_STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  net_state,
    output logic          load,
    output logic [W-1:0]  init_val,
    output logic          step_en,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_init,
    output logic [W-1:0]  res_state,
    output logic [1:0]    res_kind,
    output logic [SW-1:0] res_steps,
    output logic [W:0]    fixed_count,
    output logic          busy,
    output logic          done
);

    sweep_state_t  state, state_n;
    logic [W-1:0]  cur_init, cur_init_n;
    logic [W:0]    fixed_count_n;
    logic [W-1:0]  res_init_n, res_state_n;
    logic [1:0]    res_kind_n;
    logic [SW-1:0] res_steps_n;
    logic          mon_clear_c, mon_adv_c;
    logic [SW-1:0] step_cnt;
    logic          term_c;
    logic [1:0]    kind_c;

    gene_orbit_monitor #(
        .W         (W),
        .MAX_STEPS (MAX_STEPS),
        .SW        (SW)
    ) u_monitor (
        .clk       (clk),
        .rst       (rst),
        .clear     (mon_clear_c),
        .advance   (mon_adv_c),
        .net_state (net_state),
        .step_cnt  (step_cnt),
        .term_c    (term_c),
        .kind_c    (kind_c)
    );

    assign init_val = cur_init;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        cur_init_n    = cur_init;
        fixed_count_n = fixed_count;
        res_init_n    = res_init;
        res_state_n   = res_state;
        res_kind_n    = res_kind;
        res_steps_n   = res_steps;
        mon_clear_c   = 1'b0;
        mon_adv_c     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n       = LOAD;
                    cur_init_n    = '0;
                    fixed_count_n = '0;
                end
            end
            LOAD: begin
                mon_clear_c = 1'b1;
                state_n     = RUN;
            end
            RUN: begin
                mon_adv_c = 1'b1;
                if (term_c) begin
                    state_n     = REPORT;
                    res_init_n  = cur_init;
                    res_state_n = net_state;
                    res_kind_n  = kind_c;
                    res_steps_n = step_cnt;
                    if (kind_c == KIND_FIXED) begin
                        fixed_count_n = fixed_count + (W+1)'(1);
                    end
                end
            end
            REPORT: begin
                // Last initial is caught before the increment so cur_init never wraps
                if (res_ready) begin
                    if (cur_init == '1) begin
                        state_n = DONE;
                    end else begin
                        cur_init_n = cur_init + W'(1);
                        state_n    = LOAD;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (abort) begin
            state_n       = IDLE;
            cur_init_n    = cur_init;
            fixed_count_n = fixed_count;
            res_init_n    = res_init;
            res_state_n   = res_state;
            res_kind_n    = res_kind;
            res_steps_n   = res_steps;
            mon_adv_c     = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_init    <= '0;
            fixed_count <= '0;
            res_init    <= '0;
            res_state   <= '0;
            res_kind    <= '0;
            res_steps   <= '0;
            load        <= 1'b0;
            step_en     <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            cur_init    <= cur_init_n;
            fixed_count <= fixed_count_n;
            res_init    <= res_init_n;
            res_state   <= res_state_n;
            res_kind    <= res_kind_n;
            res_steps   <= res_steps_n;
            load        <= (state_n == LOAD);
            step_en     <= (state_n == RUN);
            res_valid   <= (state_n == REPORT);
            busy        <= (state_n != IDLE);
            done        <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_gene_sweep_controller.sv
// Directed bench for gene_sweep_controller with a behavioural gene network model.
`timescale 1ns/1ps
module tb_gene_sweep_controller;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          res_ready;
    logic [W-1:0]  net_state;
    logic          load;
    logic [W-1:0]  init_val;
    logic          step_en;
    logic          res_valid;
    logic [W-1:0]  res_init;
    logic [W-1:0]  res_state;
    logic [1:0]    res_kind;
    logic [SW-1:0] res_steps;
    logic [W:0]    fixed_count;
    logic          busy;
    logic          done;

    int tests    = 0;
    int fails    = 0;
    int mode     = 0;
    bit mon_en   = 1'b0;
    int rec_cnt  = 0;
    int rec_base = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    gene_sweep_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .net_state   (net_state),
        .load        (load),
        .init_val    (init_val),
        .step_en     (step_en),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_init    (res_init),
        .res_state   (res_state),
        .res_kind    (res_kind),
        .res_steps   (res_steps),
        .fixed_count (fixed_count),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [W-1:0] net_f(input int m, input logic [W-1:0] x);
        case (m)
            0:       return x;
            1:       return x >> 1;
            2:       return W'(x + 8'd1);
            default: return ~x;
        endcase
    endfunction

    function automatic int bitlen(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    // Gene network: loads init_val, otherwise steps while step_en is high
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            net_state <= '0;
        end else if (load) begin
            net_state <= init_val;
        end else if (step_en) begin
            net_state <= net_f(mode, net_state);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic expect_rec(input int m, input int v, output int k, output int st, output int stp);
        case (m)
            0: begin k = 0; st = v; stp = 1; end
            1: begin k = 0; st = 0; stp = bitlen(W'(v)) + 1; end
            2: begin k = 2; st = (v + 15) % 256; stp = 15; end
            default: begin
`ifdef GENE_SWEEP_CYCLE2_DETECT_EN
                k = 1; st = v; stp = 2;
`else
                k = 2; st = 255 - v; stp = 15;
`endif
            end
        endcase
    endtask

    // Record and done-pulse monitor
    always @(negedge clk) begin
        int k, st, stp, v;
        if (done) done_cnt++;
        if (mon_en && res_valid && res_ready) begin
            v = rec_cnt - rec_base;
            expect_rec(mode, v, k, st, stp);
            check("rec_init",  int'(res_init),  v);
            check("rec_kind",  int'(res_kind),  k);
            check("rec_state", int'(res_state), st);
            check("rec_steps", int'(res_steps), stp);
            rec_cnt++;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_sweep(input int m, input int exp_fc, input string tag);
        int db;
        bit seen;
        mode      = m;
        res_ready = 1'b1;
        rec_base  = rec_cnt;
        db        = done_cnt;
        mon_en    = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        repeat (3) @(negedge clk);
        check({tag, "_records"}, rec_cnt - rec_base, 256);
        check({tag, "_done_pulses"}, done_cnt - db, 1);
        check({tag, "_fixed_count"}, int'(fixed_count), exp_fc);
        check({tag, "_busy_after"}, int'(busy), 0);
        mon_en = 1'b0;
    endtask

    initial begin
        bit seen;
        int db;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        #1;
        check("rst_load",        int'(load),        0);
        check("rst_step_en",     int'(step_en),     0);
        check("rst_res_valid",   int'(res_valid),   0);
        check("rst_busy",        int'(busy),        0);
        check("rst_done",        int'(done),        0);
        check("rst_fixed_count", int'(fixed_count), 0);
        check("rst_init_val",    int'(init_val),    0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_sweep(0, 256, "ident");
        run_sweep(1, 256, "shr");
        run_sweep(2, 0,   "inc");
        run_sweep(3, 0,   "not");

        // Backpressure: hold the first record for 5 cycles
        mode      = 0;
        res_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_valid_seen", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(res_valid), 1);
            check("bp_init",  int'(res_init),  0);
            check("bp_state", int'(res_state), 0);
            check("bp_kind",  int'(res_kind),  0);
            check("bp_steps", int'(res_steps), 1);
            check("bp_load",  int'(load),      0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_rel_valid",    int'(res_valid), 0);
        check("bp_rel_load",     int'(load),      1);
        check("bp_rel_init_val", int'(init_val),  1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("bp_abort_busy", int'(busy),    0);
        check("bp_abort_load", int'(load),    0);

        // Abort in the first RUN cycle of init 3
        mode      = 0;
        res_ready = 1'b1;
        rec_base  = rec_cnt;
        db        = done_cnt;
        mon_en    = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (load && init_val == 8'd3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ab_load3_seen", int'(seen), 1);
        @(negedge clk);
        check("ab_run_step_en", int'(step_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy",        int'(busy),        0);
        check("ab_step_en",     int'(step_en),     0);
        check("ab_res_valid",   int'(res_valid),   0);
        check("ab_records",     rec_cnt - rec_base, 3);
        check("ab_fixed_count", int'(fixed_count), 3);
        repeat (5) @(negedge clk);
        check("ab_no_done",   done_cnt - db, 0);
        check("ab_idle_busy", int'(busy), 0);
        check("ab_no_record", rec_cnt - rec_base, 3);
        mon_en = 1'b0;

        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (load) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("restart_load_seen",   int'(seen),        1);
        check("restart_init_val",    int'(init_val),    0);
        check("restart_fixed_count", int'(fixed_count), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gene_sweep_controller.md
Name: gene_sweep_controller

Overview:
- Sequences the 8-bit gene network through every initial state 0..2^W-1.
- Per initial state: loads the network, steps it, and watches its output for a fixed point (x[t]==x[t-1]) or a step-limit timeout.
- Emits one result record per initial state over a valid/ready handshake, plus a running count of fixed-point initials.
- Sits between the top-level test harness and the gene network core; replaces ad-hoc per-value reset sequencing.

Parameters:
- W, 8, gene state width; sweep covers 2^W initial values.
- MAX_STEPS, 16, samples allowed per initial value before TIMEOUT (≥2).
- SW, $clog2(MAX_STEPS+1), step counter width (derived, localparam).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  terminate sweep from any state; no result emitted.
- net_state  in  W  current gene network state x[t].
- load  out  1  network loads init_val on this edge.
- init_val  out  W  initial value being loaded.
- step_en  out  1  network advances one step per edge while high.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts record.
- res_init  out  W  initial value of this record.
- res_state  out  W  final sampled state.
- res_kind  out  2  00 FIXED, 01 CYCLE2, 10 TIMEOUT.
- res_steps  out  SW  step_cnt at termination.
- fixed_count  out  W+1  number of FIXED records this sweep.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; cur_init=0; prev_valid=0; step_cnt=0; fixed_count=0.
- IDLE: start=1 → LOAD, cur_init=0, fixed_count=0. start while busy is ignored.
- LOAD (1 cycle): load=1, init_val=cur_init; step_cnt=0, prev_valid=0 → RUN. Network shows init_val from the next cycle.
- RUN: step_en=1. Each cycle:
  - If prev_valid && net_state==prev → REPORT, kind FIXED, res_state=net_state, res_steps=step_cnt, fixed_count+1.
  - Else if step_cnt==MAX_STEPS-1 → REPORT, kind TIMEOUT, res_state=net_state.
  - Else prev2<=prev, prev<=net_state, prev_valid<=1, step_cnt+1.
  - First RUN sample is the init value itself (step_cnt=0).
- REPORT: res_valid=1; res_* held stable until handshake. res_valid && res_ready:
  - cur_init==2^W-1 → DONE.
  - Otherwise cur_init+1 → LOAD.
  - res_valid is not withdrawn before acceptance.
- DONE (1 cycle): done=1 → IDLE. fixed_count holds until next start.
- abort=1 in any state: → IDLE next edge; load/step_en/res_valid drop; fixed_count retains its value. abort has priority over start, detection and the handshake.
- init_val is valid only while load=1; otherwise it holds cur_init.
- cur_init is not allowed to wrap: termination is detected by the ==2^W-1 compare, before any increment.

Optional Feature:
- Macro: GENE_SWEEP_CYCLE2_DETECT_EN.
- Defined:
  - RUN additionally tracks prev2 with a valid flag.
  - If no FIXED match and net_state==prev2 && net_state!=prev, then → REPORT, kind CYCLE2, res_steps=step_cnt.
  - FIXED has priority over CYCLE2; CYCLE2 has priority over TIMEOUT.
- Undefined: prev2 logic absent; kind 01 never produced; period-2 orbits end as TIMEOUT.

Decomposition:
- Package gene_sweep_pkg:
  - State enum: IDLE, LOAD, RUN, REPORT, DONE.
  - Kind constants: KIND_FIXED, KIND_CYCLE2, KIND_TIMEOUT.
  - Default W and MAX_STEPS.
- One sub-module, gene_orbit_monitor: holds prev/prev2/valid flags and step_cnt, compares against net_state, outputs a termination kind. The top-level FSM owns sweep, handshake and counters.

Test Plan:
- Bench network f(x)=x (identity), res_ready=1:
  - 256 records, all FIXED, res_steps=1, res_state=res_init.
  - fixed_count=256; done pulses once.
- f(x)=x>>1:
  - init 255 → FIXED, res_state=0, res_steps=9.
  - init 0 → FIXED, res_steps=1.
  - fixed_count=256.
- f(x)=x+1 mod 256:
  - Every record TIMEOUT with res_steps=15.
  - res_state=init+15 mod 256.
  - fixed_count=0.
- f(x)=~x:
  - With macro: init 0 → CYCLE2, res_steps=2.
  - Without macro: TIMEOUT, res_steps=15.
- Backpressure: hold res_ready=0 for 5 cycles in REPORT.
  - res_* stable and load stays 0 throughout.
  - Releasing res_ready gives exactly one record, then LOAD of init+1.
- abort asserted mid-RUN at init 3:
  - IDLE next cycle, no record for init 3.
  - busy=0, done never pulses.
  - A fresh start then begins at init 0.
